// File: rtl/blake_round_ctrl_if.sv
// blake_round_ctrl_if: bundles the block-input handshake, hash-output handshake,
// round-counter link and status signals of blake_round_ctrl.
//   master : environment side (block source, hash sink, blake_counter)
//   slave  : controller side (blake_round_ctrl)
// Parameter CNT_W sets the width of blk_cnt.
interface blake_round_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    localparam int unsigned IDX_W = 7;

    logic             blk_valid;
    logic             blk_last;
    logic             blk_ready;
    logic             hash_valid;
    logic             hash_ready;
    logic             round_ing;
    logic [IDX_W-1:0] counter_idx;
    logic             count_done;
    logic             load_state;
    logic             ff_en;
    logic [CNT_W-1:0] blk_cnt;
    logic             busy;
    logic             err;

    modport master (
        output blk_valid, blk_last, hash_ready, counter_idx, count_done,
        input  blk_ready, hash_valid, round_ing, load_state, ff_en, blk_cnt, busy, err
    );

    modport slave (
        input  blk_valid, blk_last, hash_ready, counter_idx, count_done,
        output blk_ready, hash_valid, round_ing, load_state, ff_en, blk_cnt, busy, err
    );
endinterface

// File: rtl/blake_round_ctrl.sv
// blake_round_ctrl: sequences one BLAKE-512 compression per accepted block:
// load pulse, one full blake_counter pass with round_ing high, feed-forward
// pulse, then (for the last block of a message) holds the hash until taken.
// Ports:
//   clk   : rising-edge clock
//   rstb  : asynchronous active-low reset
//   bus   : blake_round_ctrl_if.slave (block/hash handshakes, counter link,
//           load_state, ff_en, blk_cnt, busy, err)
// Parameters: LAST_IDX (final counter index), CNT_W (block counter width).
// Optional feature: define BLAKE_CTRL_CHECK_EN to build the sticky sequence
// checker driving err; otherwise err is tied 0.
module blake_round_ctrl #(
    parameter int unsigned LAST_IDX = 127,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rstb,
    blake_round_ctrl_if.slave   bus
);
    localparam int unsigned IDX_W = 7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ROUND,
        S_FINAL,
        S_OUT
    } state_t;

    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic blk_ready_q, blk_ready_d;
    logic round_ing_q, round_ing_d;
    logic load_q, load_d;
    logic ff_q, ff_d;
    logic hash_valid_q, hash_valid_d;
    logic busy_q, busy_d;

    // Next state plus outputs decoded from the next state, so every output is a flop
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.blk_valid && blk_ready_q) begin
                    last_d  = bus.blk_last;
                    cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
                    state_d = S_LOAD;
                end
            end
            S_LOAD:  state_d = S_ROUND;
            S_ROUND: begin
                if (bus.count_done && round_ing_q) begin
                    state_d = S_FINAL;
                end
            end
            S_FINAL: state_d = last_q ? S_OUT : S_IDLE;
            S_OUT: begin
                if (hash_valid_q && bus.hash_ready) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    last_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        blk_ready_d  = (state_d == S_IDLE);
        busy_d       = (state_d != S_IDLE);
        load_d       = (state_d == S_LOAD);
        round_ing_d  = (state_d == S_ROUND);
        ff_d         = (state_d == S_FINAL);
        hash_valid_d = (state_d == S_OUT);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q      <= S_IDLE;
            last_q       <= 1'b0;
            cnt_q        <= '0;
            blk_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            load_q       <= 1'b0;
            round_ing_q  <= 1'b0;
            ff_q         <= 1'b0;
            hash_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            cnt_q        <= cnt_d;
            blk_ready_q  <= blk_ready_d;
            busy_q       <= busy_d;
            load_q       <= load_d;
            round_ing_q  <= round_ing_d;
            ff_q         <= ff_d;
            hash_valid_q <= hash_valid_d;
        end
    end

    assign bus.blk_ready  = blk_ready_q;
    assign bus.busy       = busy_q;
    assign bus.load_state = load_q;
    assign bus.round_ing  = round_ing_q;
    assign bus.ff_en      = ff_q;
    assign bus.hash_valid = hash_valid_q;
    assign bus.blk_cnt    = cnt_q;

`ifdef BLAKE_CTRL_CHECK_EN
    logic [IDX_W-1:0] exp_idx_q;
    logic             err_q;
    logic             idx_mis;
    logic             done_mis;

    assign idx_mis  = (bus.counter_idx != exp_idx_q);
    assign done_mis = (bus.count_done != (exp_idx_q == IDX_W'(LAST_IDX)));

    // Shadow index restarts at each load; any disagreement during a round is sticky
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            exp_idx_q <= '0;
            err_q     <= 1'b0;
        end else begin
            if (load_q) begin
                exp_idx_q <= '0;
            end else if (round_ing_q) begin
                exp_idx_q <= exp_idx_q + IDX_W'(1);
            end
            if (round_ing_q && (idx_mis || done_mis)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.err = err_q;
`else
    logic unused_idx;
    assign unused_idx = (bus.counter_idx == IDX_W'(LAST_IDX));
    assign bus.err    = 1'b0;
`endif
endmodule

// File: tb/tb_blake_round_ctrl.sv
// tb_blake_round_ctrl: self-checking bench for blake_round_ctrl. Emulates
// blake_counter, drives directed and random traffic, and compares every output
// each cycle against a timing model keyed on cycles since the block handshake.
module tb_blake_round_ctrl;
    localparam int unsigned LAST_IDX = 127;
    localparam int unsigned CNT_W    = 16;
    localparam int          CNT_MAX  = (1 << CNT_W) - 1;
`ifdef BLAKE_CTRL_CHECK_EN
    localparam bit CHECK_ON = 1'b1;
`else
    localparam bit CHECK_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rstb;
    logic inj;
    logic [6:0] c_idx;

    always #5 clk = ~clk;

    blake_round_ctrl_if #(.CNT_W(CNT_W)) bus ();

    blake_round_ctrl #(.LAST_IDX(LAST_IDX), .CNT_W(CNT_W)) dut (
        .clk  (clk),
        .rstb (rstb),
        .bus  (bus.slave)
    );

    // blake_counter stand-in; inj forces an early count_done (and wrap)
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            c_idx <= '0;
        end else if (bus.round_ing) begin
            c_idx <= bus.count_done ? 7'd0 : c_idx + 7'd1;
        end
    end
    assign bus.counter_idx = c_idx;
    assign bus.count_done  = (c_idx == 7'(LAST_IDX)) || inj;

    int n_chk = 0;
    int n_bad = 0;
    int n_round;
    int n_hv;

    // Reference model: m_t = cycles since block handshake (0 when idle/out)
    int m_t;
    int m_rlen;
    int m_cnt;
    bit m_out;
    bit m_last;
    bit m_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_t    = 0;
        m_rlen = LAST_IDX + 1;
        m_cnt  = 0;
        m_out  = 1'b0;
        m_last = 1'b0;
        m_err  = 1'b0;
    endtask

    function automatic bit in_round();
        return (m_t >= 2) && (m_t <= m_rlen + 1);
    endfunction

    task automatic model_step(input logic v, input logic l, input logic hr, input logic inj_i);
        if (m_t == 0 && !m_out) begin
            if (v) begin
                m_t    = 1;
                m_last = l;
                m_rlen = LAST_IDX + 1;
                if (m_cnt < CNT_MAX) m_cnt++;
            end
        end else if (m_out) begin
            if (hr) begin
                m_out  = 1'b0;
                m_cnt  = 0;
                m_last = 1'b0;
            end
        end else if (m_t == m_rlen + 2) begin
            m_t   = 0;
            m_out = m_last;
        end else begin
            if (in_round() && inj_i && (m_t - 2) != LAST_IDX) begin
                m_rlen = m_t - 1;
                if (CHECK_ON) m_err = 1'b1;
            end
            m_t++;
        end
    endtask

    task automatic check_outs();
        bit idle;
        idle = (m_t == 0) && !m_out;
        chk("blk_ready",  32'(bus.blk_ready),  32'(idle));
        chk("busy",       32'(bus.busy),       32'(!idle));
        chk("load_state", 32'(bus.load_state), 32'(m_t == 1));
        chk("round_ing",  32'(bus.round_ing),  32'(in_round()));
        chk("ff_en",      32'(bus.ff_en),      32'(m_t == m_rlen + 2));
        chk("hash_valid", 32'(bus.hash_valid), 32'(m_out));
        chk("blk_cnt",    32'(bus.blk_cnt),    m_cnt);
        chk("err",        32'(bus.err),        32'(m_err));
    endtask

    // One clock: called at a falling edge, checks, drives, advances model
    task automatic cycle(input logic v, input logic l, input logic hr, input logic inj_i);
        check_outs();
        if (bus.round_ing) n_round++;
        if (bus.hash_valid) n_hv++;
        bus.blk_valid  = v;
        bus.blk_last   = l;
        bus.hash_ready = hr;
        inj            = inj_i;
        model_step(v, l, hr, inj_i);
        @(negedge clk);
    endtask

    initial begin
        rstb           = 1'b0;
        inj            = 1'b0;
        bus.blk_valid  = 1'b0;
        bus.blk_last   = 1'b0;
        bus.hash_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outs();
        rstb = 1'b1;

        // Single-block message with hash_ready already high
        n_round = 0;
        n_hv    = 0;
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 140; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
        chk("single_round_cycles", 32'(n_round), 32'(LAST_IDX + 1));
        chk("single_hv_cycles", 32'(n_hv), 32'd1);

        // Three-block message, last flag on the third block
        n_hv = 0;
        for (int b = 0; b < 3; b++) begin
            cycle(1'b1, (b == 2), 1'b1, 1'b0);
            for (int i = 0; i < 135; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
        end
        chk("three_blk_hv_cycles", 32'(n_hv), 32'd1);

        // Hash backpressure with a competing block offered
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 200 && !m_out; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset 60 cycles into ROUND
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 61; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        rstb = 1'b0;
        #1;
        model_reset();
        check_outs();
        chk("rst_counter_idx", 32'(bus.counter_idx), 32'd0);
        @(negedge clk);
        rstb = 1'b1;
        n_round = 0;
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 140; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
        chk("post_rst_round_cycles", 32'(n_round), 32'(LAST_IDX + 1));

        // Early count_done at expected index 50, then a clean block
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 51; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        check_outs();
        chk("inj_err_next", 32'(bus.err), 32'(CHECK_ON));
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 140; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
        chk("inj_err_sticky", 32'(bus.err), 32'(CHECK_ON));

        // Random traffic; stray count_done only outside ROUND
        for (int i = 0; i < 3000; i++) begin
            logic v, l, hr, ij;
            v  = ($urandom_range(0, 3) == 0);
            l  = ($urandom_range(0, 2) == 0);
            hr = ($urandom_range(0, 1) == 1);
            ij = !in_round() && ($urandom_range(0, 15) == 0);
            cycle(v, l, hr, ij);
        end
        for (int i = 0; i < 300; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
